rr_burst_arbiter: RTL and testbench

Round-robin, burst-locking arbiter sharing one registered output channel among three requesters. Each requester presents `WIDTH`-bit words with a `last` marker. The block grants one requester at a time, holds the grant until that requester's `last` word is accepted, and forwards words through a single valid/ready output register. It sits between the three input sources and the shared downstream consumer and replaces ad-hoc fixed-priority selection.

---
 rtl/rr_burst_arbiter.sv | 78 +++++++
 tb/tb_rr_burst_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/rr_burst_arbiter.sv
// rr_burst_arbiter: 3-way round-robin arbiter that holds a grant for a whole burst and feeds one output register. Ports: clk, res_n, input0-2/req0-2/last0-2 in, grant0-2 out, out_data/out_src/out_last/out_valid out, out_ready in.
module rr_burst_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic [WIDTH-1:0] input0,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             req0,
  input  logic             req1,
  input  logic             req2,
  input  logic             last0,
  input  logic             last1,
  input  logic             last2,
  output logic             grant0,
  output logic             grant1,
  output logic             grant2,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t           state_q, state_d;
  logic [1:0]       owner_q, owner_d, ptr_q, ptr_d, src_q, src_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d, valid_q, valid_d;
  logic [2:0]       req;
  logic [1:0]       p1, p2, cand;
  logic             has_cand, can_load, gnt, sel_last;
  logic [WIDTH-1:0] sel_data;
  assign req = {req2, req1, req0};
  always_comb begin
    p1 = ptr_q == 2'd2 ? 2'd0 : ptr_q + 2'd1;
    p2 = ptr_q == 2'd0 ? 2'd2 : ptr_q - 2'd1;
    cand = state_q == BURST ? owner_q : req[ptr_q] ? ptr_q : req[p1] ? p1 : p2;
    has_cand = state_q == BURST ? req[owner_q] : |req;
    can_load = !valid_q | out_ready;
    gnt = has_cand & can_load & res_n;
    sel_data = cand == 2'd0 ? input0 : cand == 2'd1 ? input1 : input2;
    sel_last = cand == 2'd0 ? last0 : cand == 2'd1 ? last1 : last2;
    data_d = gnt ? sel_data : data_q;
    src_d = gnt ? cand : src_q;
    last_d = gnt ? sel_last : last_q;
    valid_d = gnt | (valid_q & !out_ready);
    ptr_d = gnt & sel_last ? (cand == 2'd2 ? 2'd0 : cand + 2'd1) : ptr_q;
    state_d = gnt ? (sel_last ? IDLE : BURST) : state_q;
    owner_d = gnt & !sel_last ? cand : owner_q;
  end
  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q <= '0;
      data_q <= '0;
      src_q <= '0;
      last_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
      data_q <= data_d;
      src_q <= src_d;
      last_q <= last_d;
      valid_q <= valid_d;
    end
  end
  assign grant0 = gnt & (cand == 2'd0);
  assign grant1 = gnt & (cand == 2'd1);
  assign grant2 = gnt & (cand == 2'd2);
  assign out_data = data_q;
  assign out_src = src_q;
  assign out_last = last_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_rr_burst_arbiter.sv
// tb_rr_burst_arbiter: directed self-checking bench for rr_burst_arbiter.
module tb_rr_burst_arbiter;
  logic       clk = 1'b0, res_n;
  logic [7:0] input0, input1, input2, out_data;
  logic       req0, req1, req2, last0, last1, last2;
  logic       grant0, grant1, grant2, out_last, out_valid, out_ready;
  logic [1:0] out_src;
  logic [2:0] g;
  int vectors = 0, miscompares = 0;
  rr_burst_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .res_n(res_n),
    .input0(input0), .input1(input1), .input2(input2),
    .req0(req0), .req1(req1), .req2(req2),
    .last0(last0), .last1(last1), .last2(last2),
    .grant0(grant0), .grant1(grant1), .grant2(grant2),
    .out_data(out_data), .out_src(out_src), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );
  assign g = {grant2, grant1, grant0};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic rq(input logic [2:0] r, input logic [2:0] l);
    {req2, req1, req0} = r;
    {last2, last1, last0} = l;
    #1;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    res_n = 1'b0;
    out_ready = 1'b1;
    input0 = 8'hA0;
    input1 = 8'hB1;
    input2 = 8'hC2;
    rq(3'b111, 3'b111);
    tick;
    chk("rst_grant", 32'(g), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_src", 32'(out_src), 0);
    chk("rst_last", 32'(out_last), 0);
    tick;
    res_n = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("rr_grant", 32'(g), 32'(1 << (i % 3)));
      if (i > 0) chk("rr_src", 32'(out_src), 32'((i - 1) % 3));
      tick;
    end
    chk("rr_src_end", 32'(out_src), 2);
    chk("rr_data_end", 32'(out_data), 'hC2);
    rq(3'b111, 3'b111);
    chk("pre_grant", 32'(g), 1);
    tick;
    input1 = 8'h11;
    rq(3'b111, 3'b101);
    chk("b_g1", 32'(g), 2);
    tick;
    input1 = 8'h12;
    rq(3'b111, 3'b101);
    chk("b_g2", 32'(g), 2);
    chk("b_d1", 32'(out_data), 'h11);
    chk("b_s1", 32'(out_src), 1);
    chk("b_l1", 32'(out_last), 0);
    tick;
    input1 = 8'h13;
    rq(3'b111, 3'b111);
    chk("b_g3", 32'(g), 2);
    chk("b_d2", 32'(out_data), 'h12);
    chk("b_l2", 32'(out_last), 0);
    tick;
    rq(3'b111, 3'b111);
    chk("b_next", 32'(g), 4);
    chk("b_d3", 32'(out_data), 'h13);
    chk("b_s3", 32'(out_src), 1);
    chk("b_l3", 32'(out_last), 1);
    tick;
    chk("f_grant", 32'(g), 1);
    tick;
    input1 = 8'h21;
    rq(3'b111, 3'b101);
    chk("st_start", 32'(g), 2);
    tick;
    rq(3'b101, 3'b101);
    for (int i = 0; i < 3; i++) begin
      chk("st_grant", 32'(g), 0);
      chk("st_valid", 32'(out_valid), 32'(i == 0));
      tick;
    end
    input1 = 8'h22;
    rq(3'b111, 3'b111);
    chk("st_resume", 32'(g), 2);
    chk("st_idle_valid", 32'(out_valid), 0);
    tick;
    out_ready = 1'b0;
    input2 = 8'hC5;
    rq(3'b111, 3'b111);
    for (int i = 0; i < 4; i++) begin
      chk("bp_grant", 32'(g), 0);
      chk("bp_data", 32'(out_data), 'h22);
      chk("bp_valid", 32'(out_valid), 1);
      tick;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release", 32'(g), 4);
    chk("bp_hold", 32'(out_data), 'h22);
    tick;
    chk("bp_next_data", 32'(out_data), 'hC5);
    chk("bp_next_src", 32'(out_src), 2);
    chk("ld_grant", 32'(g), 1);
    tick;
    input2 = 8'hD0;
    rq(3'b100, 3'b000);
    chk("ld_valid", 32'(out_valid), 1);
    chk("ld_data", 32'(out_data), 'hA0);
    chk("r2_g1", 32'(g), 4);
    tick;
    input2 = 8'hD1;
    rq(3'b100, 3'b000);
    chk("r2_g2", 32'(g), 4);
    chk("r2_d1", 32'(out_data), 'hD0);
    tick;
    res_n = 1'b0;
    rq(3'b111, 3'b111);
    chk("mr_grant", 32'(g), 0);
    chk("mr_pre_data", 32'(out_data), 'hD1);
    tick;
    res_n = 1'b1;
    input1 = 8'h31;
    rq(3'b110, 3'b111);
    chk("mr_valid", 32'(out_valid), 0);
    chk("mr_data", 32'(out_data), 0);
    chk("mr_grant_after", 32'(g), 2);
    tick;
    chk("mr_cap_data", 32'(out_data), 'h31);
    chk("mr_cap_src", 32'(out_src), 1);
    chk("mr_cap_valid", 32'(out_valid), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
